pose_control_gen2: RTL

// Parametrised successor to the player button/pose controller for the raycaster.

---
 rtl/pose_control_gen2_if.sv | 26 ++
 rtl/pose_control_gen2.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pose_control_gen2_if.sv
// Pose controller bus: raw buttons and frame pulse in, published pose and status out.
// master = the side that drives buttons/frame_switch, slave = the pose controller.
interface pose_control_gen2_if #(
  parameter int WIDTH = 16
);
  logic [5:0]       btn_in;
  logic             frame_switch;
  logic [WIDTH-1:0] posX;
  logic [WIDTH-1:0] posY;
  logic [WIDTH-1:0] dirX;
  logic [WIDTH-1:0] dirY;
  logic [WIDTH-1:0] planeX;
  logic [WIDTH-1:0] planeY;
  logic             pose_updated;
  logic             busy;

  modport master (
    output btn_in, frame_switch,
    input  posX, posY, dirX, dirY, planeX, planeY, pose_updated, busy
  );

  modport slave (
    input  btn_in, frame_switch,
    output posX, posY, dirX, dirY, planeX, planeY, pose_updated, busy
  );
endinterface

// File: rtl/pose_control_gen2.sv
// Raycaster player pose controller.
// Debounces movement buttons with hold-to-repeat, arbitrates pending events into a
// sequential fixed-point move/rotate engine and publishes the working pose only at
// frame boundaries. Build macro POSE_STRAFE_EN adds the strafe channels btn_in[5:4].
//
// state   | meaning
// S_IDLE  | waiting; publishes on frame_switch/snap_pending, grants next pending channel
// S_MUL   | move: step vector (dir or plane) times MOVE_STEP
// S_ADD   | move: add/subtract product into pos, saturate to [POS_MIN, POS_MAX]
// S_MUL_D | rotate: four products of dir with cos/sin
// S_ADD_D | rotate: combine products into new dir
// S_MUL_P | rotate: four products of plane with cos/sin
// S_ADD_P | rotate: combine products into new plane
module pose_control_gen2 #(
  parameter int               WIDTH         = 16,
  parameter int               FRAC_BITS     = 8,
  parameter logic [15:0]      DEB_CYCLES    = 16'd50000,
  parameter logic [23:0]      REPEAT_DELAY  = 24'd8000000,
  parameter logic [23:0]      REPEAT_PERIOD = 24'd2000000,
  parameter logic [WIDTH-1:0] MOVE_STEP     = 'h0100,
  parameter logic [WIDTH-1:0] ROT_COS       = 'h00B5,
  parameter logic [WIDTH-1:0] ROT_SIN       = 'h00B5,
  parameter logic [WIDTH-1:0] POS_MIN       = 'h0100,
  parameter logic [WIDTH-1:0] POS_MAX       = 'h1700,
  parameter logic [WIDTH-1:0] INIT_POSX     = 'h0180,
  parameter logic [WIDTH-1:0] INIT_POSY     = 'h0180,
  parameter logic [WIDTH-1:0] INIT_DIRX     = 'h0100,
  parameter logic [WIDTH-1:0] INIT_DIRY     = 'h0000,
  parameter logic [WIDTH-1:0] INIT_PLANEX   = 'h0000,
  parameter logic [WIDTH-1:0] INIT_PLANEY   = 'h00A8
) (
  input logic                clk_in,
  input logic                rst_in,
  pose_control_gen2_if.slave bus
);

`ifdef POSE_STRAFE_EN
  localparam int NCH = 6;
`else
  localparam int NCH = 4;
`endif

  localparam logic signed [WIDTH-1:0] K_COS   = $signed(ROT_COS);
  localparam logic signed [WIDTH-1:0] K_SIN   = $signed(ROT_SIN);
  localparam logic signed [WIDTH-1:0] K_SIN_N = -$signed(ROT_SIN);
  localparam logic signed [WIDTH-1:0] K_STEP  = $signed(MOVE_STEP);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_ADD, S_MUL_D, S_ADD_D, S_MUL_P, S_ADD_P
  } state_t;

  // channel index in btn_in order: fwd, bwd, rotL, rotR, strafeL, strafeR
  typedef enum logic [2:0] {
    OP_FWD, OP_BWD, OP_ROTL, OP_ROTR, OP_STRL, OP_STRR
  } op_t;

  state_t state;
  op_t    op;

  logic signed [WIDTH-1:0] pos_x, pos_y, dir_x, dir_y, plane_x, plane_y;
  logic signed [WIDTH-1:0] pub_pos_x, pub_pos_y, pub_dir_x, pub_dir_y, pub_plane_x, pub_plane_y;
  logic signed [WIDTH-1:0] p0, p1, p2, p3;
  logic                    pose_updated_r;
  logic                    snap_pending;

  logic [NCH-1:0] evt;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] grant_vec;
  logic [NCH-1:0] grant_clr;
  op_t            grant_op;

  // Signed Q-format multiply: full-width product, floor shift, truncate.
  function automatic logic signed [WIDTH-1:0] mul_q(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    return WIDTH'(p >>> FRAC_BITS);
  endfunction

  // Position saturation; the sum carries one guard bit so it cannot wrap first.
  function automatic logic signed [WIDTH-1:0] clamp_pos(input logic signed [WIDTH:0] s);
    if (s < $signed({1'b0, POS_MIN}))
      return POS_MIN;
    else if (s > $signed({1'b0, POS_MAX}))
      return POS_MAX;
    else
      return WIDTH'(s);
  endfunction

  // Per-channel debounce and hold-to-repeat timers (both down-counters).
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [15:0] deb_cnt;
    logic [23:0] rep_cnt;
    logic        clean;
    logic        clean_q;

    // Clean level follows raw after DEB_CYCLES consecutive differing samples;
    // repeat timer runs only while the clean level stays high.
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        deb_cnt <= DEB_CYCLES - 16'd1;
        rep_cnt <= '0;
        clean   <= 1'b0;
        clean_q <= 1'b0;
      end else begin
        clean_q <= clean;
        if (bus.btn_in[i] == clean) begin
          deb_cnt <= DEB_CYCLES - 16'd1;
        end else if (deb_cnt == 16'd0) begin
          clean   <= bus.btn_in[i];
          deb_cnt <= DEB_CYCLES - 16'd1;
        end else begin
          deb_cnt <= deb_cnt - 16'd1;
        end

        if (!clean)
          rep_cnt <= '0;
        else if (!clean_q)
          rep_cnt <= REPEAT_DELAY - 24'd1;
        else if (rep_cnt == 24'd0)
          rep_cnt <= REPEAT_PERIOD - 24'd1;
        else
          rep_cnt <= rep_cnt - 24'd1;
      end
    end

    assign evt[i] = clean & (~clean_q | (rep_cnt == 24'd0));
  end

  // Fixed-priority pick among pending channels.
  always_comb begin
    grant_vec = '0;
    grant_op  = OP_FWD;
    if (pend[0]) begin
      grant_vec[0] = 1'b1;
      grant_op     = OP_FWD;
    end else if (pend[1]) begin
      grant_vec[1] = 1'b1;
      grant_op     = OP_BWD;
`ifdef POSE_STRAFE_EN
    end else if (pend[4]) begin
      grant_vec[4] = 1'b1;
      grant_op     = OP_STRL;
    end else if (pend[5]) begin
      grant_vec[5] = 1'b1;
      grant_op     = OP_STRR;
`endif
    end else if (pend[2]) begin
      grant_vec[2] = 1'b1;
      grant_op     = OP_ROTL;
    end else if (pend[3]) begin
      grant_vec[3] = 1'b1;
      grant_op     = OP_ROTR;
    end
  end

  assign grant_clr = (state == S_IDLE) ? grant_vec : '0;

  logic                    op_sub;
  logic                    op_strafe;
  logic signed [WIDTH-1:0] vec_x, vec_y;
  logic signed [WIDTH-1:0] sin_e;
  logic signed [WIDTH:0]   sum_x, sum_y;

  // Operand selection for the active op.
  always_comb begin
    op_sub    = (op == OP_BWD) || (op == OP_STRL);
    op_strafe = (op == OP_STRL) || (op == OP_STRR);
    vec_x     = op_strafe ? plane_x : dir_x;
    vec_y     = op_strafe ? plane_y : dir_y;
    sin_e     = (op == OP_ROTR) ? K_SIN_N : K_SIN;
    if (op_sub) begin
      sum_x = {pos_x[WIDTH-1], pos_x} - {p0[WIDTH-1], p0};
      sum_y = {pos_y[WIDTH-1], pos_y} - {p1[WIDTH-1], p1};
    end else begin
      sum_x = {pos_x[WIDTH-1], pos_x} + {p0[WIDTH-1], p0};
      sum_y = {pos_y[WIDTH-1], pos_y} + {p1[WIDTH-1], p1};
    end
  end

  // Engine FSM, pending bits, working pose and frame-synchronous publish.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      op             <= OP_FWD;
      pend           <= '0;
      snap_pending   <= 1'b0;
      pose_updated_r <= 1'b0;
      p0             <= '0;
      p1             <= '0;
      p2             <= '0;
      p3             <= '0;
      pos_x          <= INIT_POSX;
      pos_y          <= INIT_POSY;
      dir_x          <= INIT_DIRX;
      dir_y          <= INIT_DIRY;
      plane_x        <= INIT_PLANEX;
      plane_y        <= INIT_PLANEY;
      pub_pos_x      <= INIT_POSX;
      pub_pos_y      <= INIT_POSY;
      pub_dir_x      <= INIT_DIRX;
      pub_dir_y      <= INIT_DIRY;
      pub_plane_x    <= INIT_PLANEX;
      pub_plane_y    <= INIT_PLANEY;
    end else begin
      pose_updated_r <= 1'b0;
      // a new event on the channel being granted stays pending
      pend <= (pend & ~grant_clr) | evt;

      if (state != S_IDLE && bus.frame_switch)
        snap_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          // publish uses the pose as it stands before any op granted this cycle
          if (bus.frame_switch || snap_pending) begin
            snap_pending   <= 1'b0;
            pose_updated_r <= {pub_pos_x, pub_pos_y, pub_dir_x, pub_dir_y, pub_plane_x, pub_plane_y}
                           != {pos_x, pos_y, dir_x, dir_y, plane_x, plane_y};
            pub_pos_x      <= pos_x;
            pub_pos_y      <= pos_y;
            pub_dir_x      <= dir_x;
            pub_dir_y      <= dir_y;
            pub_plane_x    <= plane_x;
            pub_plane_y    <= plane_y;
          end
          if (|pend) begin
            op    <= grant_op;
            state <= (grant_op == OP_ROTL || grant_op == OP_ROTR) ? S_MUL_D : S_MUL;
          end
        end
        S_MUL: begin
          p0    <= mul_q(vec_x, K_STEP);
          p1    <= mul_q(vec_y, K_STEP);
          state <= S_ADD;
        end
        S_ADD: begin
          pos_x <= clamp_pos(sum_x);
          pos_y <= clamp_pos(sum_y);
          state <= S_IDLE;
        end
        S_MUL_D: begin
          p0    <= mul_q(dir_x, K_COS);
          p1    <= mul_q(dir_y, sin_e);
          p2    <= mul_q(dir_x, sin_e);
          p3    <= mul_q(dir_y, K_COS);
          state <= S_ADD_D;
        end
        S_ADD_D: begin
          dir_x <= p0 - p1;
          dir_y <= p2 + p3;
          state <= S_MUL_P;
        end
        S_MUL_P: begin
          p0    <= mul_q(plane_x, K_COS);
          p1    <= mul_q(plane_y, sin_e);
          p2    <= mul_q(plane_x, sin_e);
          p3    <= mul_q(plane_y, K_COS);
          state <= S_ADD_P;
        end
        S_ADD_P: begin
          plane_x <= p0 - p1;
          plane_y <= p2 + p3;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.posX         = pub_pos_x;
  assign bus.posY         = pub_pos_y;
  assign bus.dirX         = pub_dir_x;
  assign bus.dirY         = pub_dir_y;
  assign bus.planeX       = pub_plane_x;
  assign bus.planeY       = pub_plane_y;
  assign bus.pose_updated = pose_updated_r;
  assign bus.busy         = (state != S_IDLE);

endmodule
